booth_mult_ctrl: RTL and testbench
==================================

// Module: booth_mult_ctrl
// PURPOSE
//  Multi-cycle signed 32x32 multiplier controller (radix-2 Booth).
//  Owns no adder: drives one external 32-bit CLA adder through the adder_* ports and takes one add/sub/pass step per cycle.
//  Delivers the low 32 product bits and an overflow flag to the execute stage.
//  Sits beside the ALU so the ALU's adder instance can be shared.
// PARAMETERS
//  WIDTH    32  operand/product width; fixed by the adder, do not override
//  CNT_W    6   iteration counter width; must hold the value WIDTH
// PORTS
//  clock         in   1   single system clock; all state updates on posedge
//  reset         in   1   synchronous, active-low; sampled on posedge clock
//  start         in   1   request; accepted only while busy==0
//  multiplicand  in   32  M, signed; sampled at the accepting edge
//  multiplier    in   32  Q, signed; sampled at the accepting edge
//  busy          out  1   high in RUN and DONE
//  result_valid  out  1   one-cycle pulse in DONE
//  product       out  32  low 32 bits of M*Q; held until the next accept
//  overflow      out  1   1 if M*Q does not fit in signed 32 bits; held with product
//  adder_a       out  32  adder operand A (= HI register)
//  adder_b       out  32  adder operand B (M, ~M or 0)
//  adder_cin     out  1   adder carry-in (1 only for subtract)
//  adder_sum     in   32  adder sum, combinational return
//  adder_ovf     in   1   adder signed overflow, combinational return
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE; HI, LO, Q_1, M, count cleared.
//   - busy=0, result_valid=0, product=0, overflow=0.
//   - Overrides any operation in flight; the partial result is discarded.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: on start==1, load M<=multiplicand, LO<=multiplier, HI<=0, Q_1<=0, count<=0, go to RUN.
//   - RUN: one Booth step per cycle, keyed on {LO[0],Q_1}:
//     01 -> adder_b=M, cin=0 (add)
//     10 -> adder_b=~M, cin=1 (subtract)
//     00/11 -> adder_b=0, cin=0 (pass)
//   - RUN, every step:
//     - true sign s = adder_sum[31] ^ adder_ovf (the 33rd bit of the step result).
//     - Arithmetic shift right of {s,adder_sum,LO}: HI<={s,adder_sum[31:1]}, LO<={adder_sum[0],LO[31:1]}, Q_1<=LO[0].
//     - count<=count+1.
//     - After the step with count==WIDTH-1, go to DONE.
//   - DONE: product<=LO; overflow<=(HI != {32{LO[31]}}); result_valid=1 for this cycle; go to IDLE next edge.
//  Latency: accepting edge k, RUN on edges k+1..k+32, result_valid high during the cycle after edge k+33. Back-to-back issue every 34 cycles.
//  start while busy==1 (RUN or DONE): ignored, no queueing.
//  In IDLE and DONE: adder_b=0, adder_cin=0, adder_a=HI (adder output unused).
//  Adder ports are combinational from registers only; no combinational path from adder_sum to any adder_* output.
//  M, Q unchanged mid-run even if the input buses change.
//  Edge cases:
//   - M=0x80000000 is handled by the s-correction; no extra cycle.
//   - Q=0x80000000 needs no special case.
// STRUCTURE
//  Shared include booth_mult_defs.vh:
//   - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2; 2'd3 is illegal and decodes to IDLE.
//   - Booth op codes OP_PASS, OP_ADD, OP_SUB.
//  Sub-module booth_operand_sel (combinational): {LO[0],Q_1},M -> adder_b, adder_cin.
//  Counter and FSM stay in the top module.
// TESTING
//  1. 3*4: start 1 cycle -> busy for 34 cycles; result_valid pulse 34 cycles after the accepting edge; product=0x0000000C, overflow=0.
//  2. -1*-1 (0xFFFFFFFF x2) -> product=0x00000001, overflow=0; -7*6 -> product=0xFFFFFFD6, overflow=0.
//  3. 0x7FFFFFFF*2 -> product=0xFFFFFFFE, overflow=1; 0x80000000*0xFFFFFFFF -> product=0x80000000, overflow=1.
//  4. 0x80000000*0x80000000 (exercises adder_ovf correction) -> product=0x00000000, overflow=1; 0x80000000*1 -> product=0x80000000, overflow=0.
//  5. start pulsed at cycles 5 and 20 after an accept -> the second start is ignored; exactly one result_valid; product from the first operands.
//  6. reset low at RUN step 10 -> next cycle busy=0, product=0, overflow=0, no result_valid; a new 5*5 afterwards -> product=0x00000019.

Source files
------------

// File: rtl/booth_mult_ctrl_pkg.sv
// Shared encodings for the radix-2 Booth multiplier controller:
// FSM state codes, Booth step op codes and the recode helper.
package booth_mult_ctrl_pkg;

    localparam int BOOTH_WIDTH = 32;
    localparam int BOOTH_CNT_W = 6;

    // 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } op_t;

    // Radix-2 Booth recode of {LO[0], Q_1}.
    function automatic op_t booth_op(input logic [1:0] bits);
        op_t op;
        case (bits)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_PASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_ctrl_operand_sel.sv
// Booth operand select: turns the current multiplier bit pair into the
// B operand and carry-in of the shared adder. Subtract is done as
// A + ~M + 1, so carry-in is set only for OP_SUB.
module booth_operand_sel
    import booth_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       booth_bits,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin
);

    // Select M, ~M or zero according to the recoded op.
    always_comb begin
        adder_b   = '0;
        adder_cin = 1'b0;
        case (booth_op(booth_bits))
            OP_ADD: begin
                adder_b   = m;
                adder_cin = 1'b0;
            end
            OP_SUB: begin
                adder_b   = ~m;
                adder_cin = 1'b1;
            end
            default: begin
                adder_b   = '0;
                adder_cin = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Multi-cycle signed multiplier controller (radix-2 Booth) driving an
// external shared adder, one add/sub/pass step per clock.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | waiting for start; operands load on the accepting edge
//   S_RUN  | one Booth step per cycle, WIDTH steps total
//   S_DONE | product/overflow registered, result_valid pulses next cycle
//
// result_valid, product and overflow are registered on the edge that
// leaves DONE, so they appear together in the following cycle. busy
// also covers that delivery cycle, which gives a 34-cycle issue
// interval and keeps a start in the result cycle from being accepted.
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_ovf
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             q_1;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_step;
    logic             step_sign;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;

    assign busy      = (state != S_IDLE) || result_valid;
    assign accept    = start && !busy;
    assign last_step = (count == CNT_W'(WIDTH - 1));

    // 33rd bit of the step result: corrects the sign when the adder overflows.
    assign step_sign = adder_sum[WIDTH-1] ^ adder_ovf;

    booth_operand_sel #(
        .WIDTH (WIDTH)
    ) u_operand_sel (
        .booth_bits (state == S_RUN ? {lo[0], q_1} : 2'b00),
        .m          (m),
        .adder_b    (sel_b),
        .adder_cin  (sel_cin)
    );

    assign adder_a   = hi;
    assign adder_b   = sel_b;
    assign adder_cin = sel_cin;

    // Next-state decode; the unused code falls back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = accept ? S_RUN : S_IDLE;
            S_RUN:   next_state = last_step ? S_DONE : S_RUN;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State, datapath registers and result delivery, synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            hi           <= '0;
            lo           <= '0;
            q_1          <= 1'b0;
            m            <= '0;
            count        <= '0;
            product      <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= next_state;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        m     <= multiplicand;
                        lo    <= multiplier;
                        hi    <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                    end
                end
                S_RUN: begin
                    hi    <= {step_sign, adder_sum[WIDTH-1:1]};
                    lo    <= {adder_sum[0], lo[WIDTH-1:1]};
                    q_1   <= lo[0];
                    count <= count + CNT_W'(1);
                end
                S_DONE: begin
                    product      <= lo;
                    overflow     <= (hi != {WIDTH{lo[WIDTH-1]}});
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl with a behavioural model of the
// shared 32-bit adder. Expected products are hand-computed constants.
module tb_booth_mult_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        result_valid;
    logic [31:0] product;
    logic        overflow;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic        adder_cin;
    logic [31:0] adder_sum;
    logic        adder_ovf;
    logic [32:0] add_full;

    int checks = 0;
    int errors = 0;

    booth_mult_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .result_valid (result_valid),
        .product      (product),
        .overflow     (overflow),
        .adder_a      (adder_a),
        .adder_b      (adder_b),
        .adder_cin    (adder_cin),
        .adder_sum    (adder_sum),
        .adder_ovf    (adder_ovf)
    );

    assign add_full  = {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, adder_cin};
    assign adder_sum = add_full[31:0];
    assign adder_ovf = (adder_a[31] == adder_b[31]) && (adder_sum[31] != adder_a[31]);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one multiply and follow it to completion. With disturb set,
    // start is re-pulsed at cycles 5 and 20 with different operands.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_p, input logic exp_o, input bit disturb);
        int          busy_cnt;
        int          valid_cnt;
        int          valid_at;
        logic [31:0] got_p;
        logic        got_o;
        bit          done;
        busy_cnt  = 0;
        valid_cnt = 0;
        valid_at  = -1;
        got_p     = 32'hDEAD_BEEF;
        got_o     = 1'bx;
        done      = 1'b0;
        @(negedge clock);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        // First RUN cycle: HI is zero and the step is decided by Q[0] alone.
        chk({tag, "_a0"}, adder_a, 32'h0);
        chk({tag, "_b0"}, adder_b, b[0] ? ~a : 32'h0);
        chk({tag, "_cin0"}, {31'd0, adder_cin}, {31'd0, b[0]});
        for (int n = 0; n < 60 && !done; n++) begin
            if (n > 0) @(negedge clock);
            start = 1'b0;
            if (disturb && (n == 5 || n == 20)) begin
                start        = 1'b1;
                multiplicand = 32'h1234_5678;
                multiplier   = 32'h0000_0003;
            end
            if (busy) busy_cnt++;
            else done = 1'b1;
            if (result_valid) begin
                valid_cnt++;
                valid_at = n;
                got_p    = product;
                got_o    = overflow;
            end
        end
        start = 1'b0;
        chk({tag, "_finished"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd34);
        chk({tag, "_valid_count"}, 32'(valid_cnt), 32'd1);
        chk({tag, "_valid_at"}, 32'(valid_at), 32'd33);
        chk({tag, "_product"}, got_p, exp_p);
        chk({tag, "_overflow"}, {31'd0, got_o}, {31'd0, exp_o});
        chk({tag, "_held"}, product, exp_p);
    endtask

    initial begin
        int rv_seen;
        reset        = 1'b0;
        start        = 1'b0;
        multiplicand = 32'h0;
        multiplier   = 32'h0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_product", product, 32'h0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_adder_b", adder_b, 32'h0);
        chk("rst_adder_cin", {31'd0, adder_cin}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        run_mult("m3x4", 32'd3, 32'd4, 32'h0000_000C, 1'b0, 1'b0);
        run_mult("mneg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_mult("mneg7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, 1'b0);
        run_mult("mmaxx2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_mult("mminxneg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        run_mult("mminxmin", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_mult("mminx1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 1'b0);
        run_mult("mignore", 32'd11, 32'd13, 32'h0000_008F, 1'b0, 1'b1);

        // Reset in the middle of a run discards the operation.
        @(negedge clock);
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        chk("midrun_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("midrun_busy", {31'd0, busy}, 32'd0);
        chk("midrun_product", product, 32'h0);
        chk("midrun_overflow", {31'd0, overflow}, 32'd0);
        chk("midrun_valid", {31'd0, result_valid}, 32'd0);
        reset   = 1'b1;
        rv_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (result_valid) rv_seen++;
        end
        chk("midrun_no_valid", 32'(rv_seen), 32'd0);
        chk("midrun_idle", {31'd0, busy}, 32'd0);

        run_mult("m5x5", 32'd5, 32'd5, 32'h0000_0019, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
